// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
//   Sequences the two cascaded line-buffer FIFOs that feed a 3x3 median window.
//   It counts the accepted raster pixels, drives the line buffers' reset and
//   read/write enables, and flags each complete 3x3 window with its centre.
//   Optional feature macro: LB_STALL_EN. When it is defined, a win_ready_i
//   port lets downstream back-pressure the stream and hold a window.
module line_buffer_ctrl #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int LB_PRIME   = 253
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
`ifdef LB_STALL_EN
  input  logic                          win_ready_i,
`endif
  output logic                          lb_rst_o,
  output logic                          lb0_wr_en_o,
  output logic                          lb0_rd_en_o,
  output logic                          lb1_wr_en_o,
  output logic                          lb1_rd_en_o,
  output logic                          win_valid_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col_o,
  output logic                          busy_o,
  output logic                          frame_done_o
);

  localparam int COL_W    = $clog2(IMG_WIDTH);
  localparam int ROW_W    = $clog2(IMG_HEIGHT);
  localparam int FILL_CNT = 2 * IMG_WIDTH + 2;
  localparam int LB1_CNT  = IMG_WIDTH + LB_PRIME;
  localparam int CNT_MAX  = (LB1_CNT > FILL_CNT) ? LB1_CNT : FILL_CNT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FILL_CNT);
  localparam logic [CNT_W-1:0] CNT_FILL_M = CNT_W'(FILL_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_LB0    = CNT_W'(LB_PRIME);
  localparam logic [CNT_W-1:0] CNT_LB1    = CNT_W'(LB1_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_valid_q, win_valid_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic             accept;
  logic             last_pix;
  logic             win_hold;

  assign busy_o = (state_q == ST_FILL) || (state_q == ST_STREAM);

`ifdef LB_STALL_EN
  assign pix_ready_o = (state_q == ST_FILL) || ((state_q == ST_STREAM) && win_ready_i);
  assign win_hold    = win_valid_q && !win_ready_i;
`else
  assign pix_ready_o = busy_o;
  assign win_hold    = 1'b0;
`endif

  assign accept   = pix_valid_i && pix_ready_o;
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Line-buffer enables: every enable is qualified by accept so both FIFOs stall together.
  assign lb0_wr_en_o = accept;
  assign lb0_rd_en_o = accept && (cnt_q >= CNT_LB0);
  assign lb1_wr_en_o = lb0_rd_en_o;
  assign lb1_rd_en_o = accept && (cnt_q >= CNT_LB1);

  assign win_valid_o = win_valid_q;
  assign win_row_o   = win_row_q;
  assign win_col_o   = win_col_q;

  // State register.
  // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode plus the state-only outputs.
  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    lb_rst_o     = 1'b0;
    frame_done_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        lb_rst_o = 1'b1;
        if (start_i) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (accept && (cnt_q == CNT_FILL_M)) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept && last_pix) state_d = ST_DONE;
      end
      ST_DONE: begin
        lb_rst_o     = 1'b1;
        frame_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster position and priming count: cleared on a honoured start, advanced only on accept.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) && start_i) begin
      col_d = '0;
      row_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end
  end

  // Window flag: a pixel at col>=2 and row>=2 completes the window centred one up and one left.
  always_comb begin
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (!win_hold) begin
      win_valid_d = accept && (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));
      if (win_valid_d) begin
        win_row_d = row_q - 1'b1;
        win_col_d = col_q - 1'b1;
      end
    end
  end

  // Counter and window registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

endmodule
